// File: rtl/scale_snap.sv
// Snaps each debounced detected note to the nearest note allowed by a 12-bit
// scale mask, searching outward one candidate per cycle (flat side first).
module scale_snap #(
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        note_done,
  input  logic [3:0]  note_name,
  input  logic [2:0]  note_octave,
  input  logic [11:0] scale,
  output logic [3:0]  target_name,
  output logic [2:0]  target_octave,
  output logic [3:0]  shift,
  output logic        no_match,
  output logic        target_valid,
  output logic        busy
);

  typedef enum logic {IDLE, SEARCH} state_t;

  localparam logic [2:0] STABLE_CNT = 3'(STABLE_FRAMES);

  state_t      state, state_next;
  logic [2:0]  stable_cnt, cnt_next;
  logic        prev_valid;
  logic [3:0]  prev_name;
  logic [2:0]  prev_octave;
  logic [3:0]  lat_name;
  logic [2:0]  lat_octave;
  logic [11:0] lat_scale;
  logic [3:0]  k;

  logic        note_ok, same_note, start;
  logic [3:0]  mag;
  logic [5:0]  d, n_raw;
  logic [3:0]  cand_name;
  logic [2:0]  cand_octave;
  logic        oct_ok, cand_ok, last;
  logic [15:0] scale_ext;

  always_comb begin
    note_ok   = note_name < 4'd12;
    same_note = prev_valid && (prev_name == note_name) && (prev_octave == note_octave);
    cnt_next  = 3'd1;
    if (same_note)
      cnt_next = (stable_cnt == 3'd7) ? 3'd7 : stable_cnt + 3'd1;
    start = (state == IDLE) && note_done && note_ok && (cnt_next == STABLE_CNT);
  end

  // Candidate k maps to offset 0,-1,+1,-2,+2,...: odd k is the flat side.
  always_comb begin
    mag         = (k + 4'd1) >> 1;
    d           = k[0] ? (6'd0 - {2'b00, mag}) : {2'b00, mag};
    n_raw       = {2'b00, lat_name} + d;
    cand_name   = n_raw[3:0];
    cand_octave = lat_octave;
    oct_ok      = 1'b1;
    if (n_raw[5]) begin
      cand_name   = n_raw[3:0] + 4'd12;
      cand_octave = lat_octave - 3'd1;
      oct_ok      = lat_octave != 3'd0;
    end else if (n_raw > 6'd11) begin
      cand_name   = n_raw[3:0] - 4'd12;
      cand_octave = lat_octave + 3'd1;
      oct_ok      = lat_octave != 3'd7;
    end
    scale_ext = {4'b0000, lat_scale};
    cand_ok   = oct_ok && scale_ext[cand_name];
    last      = k == 4'd12;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SEARCH;
      SEARCH:  if (cand_ok || last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = state == SEARCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_cnt    <= '0;
      prev_valid    <= 1'b0;
      prev_name     <= '0;
      prev_octave   <= '0;
      lat_name      <= '0;
      lat_octave    <= '0;
      lat_scale     <= '0;
      k             <= '0;
      target_name   <= '0;
      target_octave <= '0;
      shift         <= '0;
      no_match      <= 1'b0;
      target_valid  <= 1'b0;
    end else begin
      target_valid <= 1'b0;
      if ((state == IDLE) && note_done) begin
        if (!note_ok) begin
          stable_cnt <= '0;
          prev_valid <= 1'b0;
        end else begin
          stable_cnt  <= cnt_next;
          prev_valid  <= 1'b1;
          prev_name   <= note_name;
          prev_octave <= note_octave;
        end
      end
      if (start) begin
        lat_name   <= note_name;
        lat_octave <= note_octave;
        lat_scale  <= scale;
        k          <= '0;
      end else if (state == SEARCH) begin
        if (cand_ok) begin
          target_name   <= cand_name;
          target_octave <= cand_octave;
          shift         <= d[3:0];
          no_match      <= 1'b0;
          target_valid  <= 1'b1;
        end else if (last) begin
          target_name   <= lat_name;
          target_octave <= lat_octave;
          shift         <= '0;
          no_match      <= 1'b1;
          target_valid  <= 1'b1;
        end else begin
          k <= k + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scale_snap.sv
// Self-checking bench for scale_snap: two instances (STABLE_FRAMES 1 and 2),
// table-driven vectors plus hand sequences, with a per-instance scoreboard.
module tb_scale_snap;

  typedef struct {
    logic [3:0]  name;
    logic [2:0]  oct;
    logic [3:0]  shift;
    logic        nm;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    int          sel;
    int          frames;
    logic [3:0]  name;
    logic [2:0]  oct;
    logic [11:0] scale;
    logic [3:0]  ename;
    logic [2:0]  eoct;
    logic [3:0]  eshift;
    logic        enm;
    int          k;
  } vec_t;

  localparam logic [11:0] S_MAIN = 12'b111011010111;
  localparam logic [11:0] S_C    = 12'b000000000001;
  localparam logic [11:0] S_B    = 12'b100000000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        nd [2];
  logic [3:0]  nn [2];
  logic [2:0]  no [2];
  logic [11:0] sc [2];
  logic [3:0]  tn [2];
  logic [2:0]  to [2];
  logic [3:0]  sh [2];
  logic        nm [2];
  logic        tv [2];
  logic        bz [2];

  exp_t        sb0[$];
  exp_t        sb1[$];
  vec_t        vecs[11];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  scale_snap #(.STABLE_FRAMES(1)) u_sf1 (
    .clk(clk), .reset(reset), .note_done(nd[0]), .note_name(nn[0]),
    .note_octave(no[0]), .scale(sc[0]), .target_name(tn[0]),
    .target_octave(to[0]), .shift(sh[0]), .no_match(nm[0]),
    .target_valid(tv[0]), .busy(bz[0])
  );

  scale_snap #(.STABLE_FRAMES(2)) u_sf2 (
    .clk(clk), .reset(reset), .note_done(nd[1]), .note_name(nn[1]),
    .note_octave(no[1]), .scale(sc[1]), .target_name(tn[1]),
    .target_octave(to[1]), .shift(sh[1]), .no_match(nm[1]),
    .target_valid(tv[1]), .busy(bz[1])
  );

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", what, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (tv[s] === 1'b1) begin
        if ((s == 0 ? sb0.size() : sb1.size()) == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse dut%0d: target_valid=1, expected 0 (cycle %0d)", s, cyc);
        end else begin
          if (s == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          check($sformatf("pulse_cycle_dut%0d", s), cyc, e.cyc);
          check($sformatf("target_name_dut%0d", s), {28'd0, tn[s]}, {28'd0, e.name});
          check($sformatf("target_octave_dut%0d", s), {29'd0, to[s]}, {29'd0, e.oct});
          check($sformatf("shift_dut%0d", s), {28'd0, sh[s]}, {28'd0, e.shift});
          check($sformatf("no_match_dut%0d", s), {31'd0, nm[s]}, {31'd0, e.nm});
          check($sformatf("busy_at_pulse_dut%0d", s), {31'd0, bz[s]}, 32'd0);
        end
      end
    end
  endtask

  // One clock: sample outputs on the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame(input int sel, input logic [3:0] n, input logic [2:0] o, input logic [11:0] s);
    nn[sel] = n;
    no[sel] = o;
    sc[sel] = s;
    nd[sel] = 1'b1;
    tick();
    nd[sel] = 1'b0;
  endtask

  task automatic expect_pulse(input int sel, input logic [3:0] n, input logic [2:0] o,
                              input logic [3:0] s, input logic m, input int k);
    exp_t e;
    e.name  = n;
    e.oct   = o;
    e.shift = s;
    e.nm    = m;
    e.cyc   = cyc + 2 + k;
    if (sel == 0) sb0.push_back(e);
    else          sb1.push_back(e);
  endtask

  task automatic drain(input int sel);
    for (int i = 0; i < 40 && (sel == 0 ? sb0.size() : sb1.size()) != 0; i++) tick();
    check($sformatf("drain_pending_dut%0d", sel), (sel == 0) ? sb0.size() : sb1.size(), 32'd0);
    if (sel == 0) sb0.delete();
    else          sb1.delete();
    idle(3);
  endtask

  task automatic check_zero(input int s);
    check($sformatf("zero_target_name_dut%0d", s), {28'd0, tn[s]}, 32'd0);
    check($sformatf("zero_target_octave_dut%0d", s), {29'd0, to[s]}, 32'd0);
    check($sformatf("zero_shift_dut%0d", s), {28'd0, sh[s]}, 32'd0);
    check($sformatf("zero_no_match_dut%0d", s), {31'd0, nm[s]}, 32'd0);
    check($sformatf("zero_target_valid_dut%0d", s), {31'd0, tv[s]}, 32'd0);
    check($sformatf("zero_busy_dut%0d", s), {31'd0, bz[s]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        sel fr name oct scale   ename eoct eshift  nm  k
    vecs[0]  = '{1, 2, 4'd7,  3'd3, S_MAIN,       4'd7,  3'd3, 4'h0, 1'b0, 0};
    vecs[1]  = '{0, 1, 4'd3,  3'd4, S_MAIN,       4'd2,  3'd4, 4'hF, 1'b0, 1};
    vecs[2]  = '{0, 1, 4'd5,  3'd4, S_MAIN,       4'd4,  3'd4, 4'hF, 1'b0, 1};
    vecs[3]  = '{0, 1, 4'd11, 3'd3, S_C,          4'd0,  3'd4, 4'h1, 1'b0, 2};
    vecs[4]  = '{0, 1, 4'd0,  3'd0, S_B,          4'd0,  3'd0, 4'h0, 1'b1, 12};
    vecs[5]  = '{0, 1, 4'd9,  3'd5, 12'h000,      4'd9,  3'd5, 4'h0, 1'b1, 12};
    vecs[6]  = '{1, 2, 4'd8,  3'd3, 12'h004,      4'd2,  3'd3, 4'hA, 1'b0, 11};
    vecs[7]  = '{0, 1, 4'd2,  3'd0, 12'h100,      4'd8,  3'd0, 4'h6, 1'b0, 12};
    vecs[8]  = '{0, 1, 4'd11, 3'd7, S_C,          4'd11, 3'd7, 4'h0, 1'b1, 12};
    vecs[9]  = '{1, 2, 4'd0,  3'd1, 12'hFFF,      4'd0,  3'd1, 4'h0, 1'b0, 0};
    vecs[10] = '{0, 1, 4'd1,  3'd6, 12'h005,      4'd0,  3'd6, 4'hF, 1'b0, 1};

    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      nd[s] = 1'b0;
      nn[s] = '0;
      no[s] = '0;
      sc[s] = '0;
    end
    @(posedge clk);
    #1;
    idle(3);
    check_zero(0);
    check_zero(1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      frame(vecs[i].sel, 4'd15, 3'd0, vecs[i].scale);
      tick();
      for (int f = 0; f < vecs[i].frames; f++) begin
        if (f == vecs[i].frames - 1)
          expect_pulse(vecs[i].sel, vecs[i].ename, vecs[i].eoct, vecs[i].eshift, vecs[i].enm, vecs[i].k);
        frame(vecs[i].sel, vecs[i].name, vecs[i].oct, vecs[i].scale);
      end
      check($sformatf("busy_after_start_vec%0d", i), {31'd0, bz[vecs[i].sel]}, 32'd1);
      drain(vecs[i].sel);
    end

    // Debounce: a changed note restarts the count; a held note searches once.
    frame(1, 4'd15, 3'd0, S_MAIN);
    frame(1, 4'd4, 3'd3, S_MAIN);
    check("debounce_busy_f1", {31'd0, bz[1]}, 32'd0);
    frame(1, 4'd7, 3'd3, S_MAIN);
    check("debounce_busy_f2", {31'd0, bz[1]}, 32'd0);
    expect_pulse(1, 4'd7, 3'd3, 4'h0, 1'b0, 0);
    frame(1, 4'd7, 3'd3, S_MAIN);
    drain(1);
    frame(1, 4'd7, 3'd3, S_MAIN);
    check("debounce_busy_f4", {31'd0, bz[1]}, 32'd0);
    idle(20);

    // An invalid note between two identical notes clears the history.
    frame(1, 4'd15, 3'd0, S_MAIN);
    frame(1, 4'd2, 3'd5, S_MAIN);
    frame(1, 4'd15, 3'd5, S_MAIN);
    frame(1, 4'd2, 3'd5, S_MAIN);
    check("invalid_between_busy", {31'd0, bz[1]}, 32'd0);
    idle(5);
    expect_pulse(1, 4'd2, 3'd5, 4'h0, 1'b0, 0);
    frame(1, 4'd2, 3'd5, S_MAIN);
    drain(1);

    // Events during SEARCH are dropped: result unchanged, history untouched.
    frame(0, 4'd15, 3'd0, S_B);
    expect_pulse(0, 4'd0, 3'd0, 4'h0, 1'b1, 12);
    frame(0, 4'd0, 3'd0, S_B);
    for (int i = 0; i < 5; i++) begin
      frame(0, 4'd3, 3'd4, S_MAIN);
      tick();
    end
    drain(0);
    frame(0, 4'd0, 3'd0, S_B);
    check("held_note_busy", {31'd0, bz[0]}, 32'd0);
    idle(20);

    // Reset mid-search, with a coincident note_done on the other instance.
    frame(1, 4'd15, 3'd0, S_B);
    frame(1, 4'd0, 3'd0, S_B);
    frame(1, 4'd0, 3'd0, S_B);
    check("reset_search_busy", {31'd0, bz[1]}, 32'd1);
    idle(2);
    reset = 1'b1;
    nn[0] = 4'd2;
    no[0] = 3'd1;
    sc[0] = S_MAIN;
    nd[0] = 1'b1;
    tick();
    check_zero(0);
    check_zero(1);
    reset = 1'b0;
    nd[0] = 1'b0;
    idle(20);
    frame(1, 4'd0, 3'd0, S_MAIN);
    check("post_reset_single_busy", {31'd0, bz[1]}, 32'd0);
    idle(3);
    expect_pulse(1, 4'd0, 3'd0, 4'h0, 1'b0, 0);
    frame(1, 4'd0, 3'd0, S_MAIN);
    drain(1);
    expect_pulse(0, 4'd2, 3'd1, 4'h0, 1'b0, 0);
    frame(0, 4'd2, 3'd1, S_MAIN);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/scale_snap.md
# scale_snap

Downstream of the note detector (`main_fsm`), `scale_snap` turns each detected note into the nearest note allowed by the 12-bit scale mask. It debounces successive `note_done` results over a programmable number of frames, then walks outward from the detected note one candidate per cycle. It emits the target note, its octave and the signed semitone correction for the pitch-shift stage. That result is qualified by a one-cycle `target_valid` pulse.

## Interface
- `STABLE_FRAMES`, default 2: consecutive identical detections (same name and octave) required before a search; legal range 1..7.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `note_done` in 1: one-cycle pulse marking `note_name`/`note_octave` valid.
- `note_name` in 4: detected note, 0=C .. 11=B; values 12..15 mean "no pitch".
- `note_octave` in 3: detected octave, 0..7.
- `scale` in 12: bit i set means note i is allowed; sampled at search start.
- `target_name` out 4: snapped note, 0..11.
- `target_octave` out 3: snapped octave.
- `shift` out 4: signed two's-complement correction, target minus detected, range -6..+6.
- `no_match` out 1: set with `target_valid` when no candidate is legal.
- `target_valid` out 1: one-cycle pulse; the other outputs are updated in the same cycle.
- `busy` out 1: high while in SEARCH.

## Operation
- States:
  - IDLE: waiting for `note_done`.
  - SEARCH: checks candidate index k = 0..12, one per cycle.
- Reset behaviour:
  - All outputs are 0; `target_name` and `target_octave` are 0.
  - State goes to IDLE; the stability counter is 0 and the previous-note register is cleared (marked invalid).
- `note_done` in IDLE with `note_name` ≥ 12:
  - Counter goes to 0 and the previous-note register is marked invalid.
  - No search and no output.
- `note_done` in IDLE with a valid note:
  - If name and octave equal the previous note, counter = min(counter+1, 7); otherwise counter = 1.
  - The previous-note register is loaded in both cases.
  - If the resulting counter equals `STABLE_FRAMES`, latch name, octave and `scale`, go to SEARCH with k=0.
  - If the counter is already above `STABLE_FRAMES`, do not search again; the output is held until the note changes.
- `note_done` while in SEARCH is dropped. It does not affect the counter or the previous-note register.
- Candidate order, as offset d from the detected note: 0, -1, +1, -2, +2, -3, +3, -4, +4, -5, +5, -6, +6. Ties resolve downward (the flat side is preferred).
- Candidate note arithmetic: n = name + d.
  - If n < 0: n += 12 and octave -= 1.
  - If n > 11: n -= 12 and octave += 1.
- A candidate whose octave would leave 0..7 is skipped: it is treated as not allowed.
- Match: the first candidate with `scale[n]`=1.
  - Register the target and `shift` = d, clear `no_match`, pulse `target_valid`, return to IDLE.
- Exhaustion: after k=12 with no match:
  - `target_name`/`target_octave` = detected note, `shift` = 0, `no_match` = 1.
  - Pulse `target_valid` and return to IDLE.
  - An all-zero `scale` always exhausts.
- Output hold: outputs hold their values between pulses.

## Timing
- Search start: `note_done` is sampled at edge E0. If the stability threshold is met there, SEARCH and `busy` are high from E0.
- Candidate k is evaluated at edge E0+1+k.
- On a match at candidate k, `target_valid` is high for exactly the cycle after edge E0+1+k, and `busy` falls in that same cycle.
- Latency from `note_done` to `target_valid` is 2+k cycles:
  - Minimum 2 (in-scale note).
  - Maximum 14, both for a match at candidate 12 and for exhaustion.
- `target_valid` never asserts on two consecutive cycles.
- `reset` asserted during SEARCH:
  - Next cycle is IDLE with all outputs 0 and no `target_valid`.
  - The stability history is lost.
- `note_done` coincident with `reset`: ignored.

## Test plan
- Debounce, with STABLE_FRAMES=2 and `scale`=12'b111011010111:
  - Stimulus: `note_done` frames (4,o3), (7,o3), (7,o3).
  - Required: no pulse on frames 1-2. After frame 3, `target_valid` after 2 cycles with target 7/o3, `shift`=0.
  - Follow-up: a fourth (7,o3) produces no pulse.
- Snap down, same scale, STABLE_FRAMES=1:
  - Stimulus: note 3/o4.
  - Required: target 2/o4, `shift`=-1 (4'b1111), pulse 3 cycles after `note_done`.
  - Stimulus: note 5/o4.
  - Required: target 4/o4, `shift`=-1.
- Octave wrap up, `scale`=12'b000000000001 (C only), STABLE_FRAMES=1:
  - Stimulus: note 11/o3.
  - Required: target 0/o4, `shift`=+1, latency 4 cycles.
- Boundary and no-match, `scale`=12'b100000000000 (B only):
  - Stimulus: note 0/o0.
  - Required: negative candidates skipped, all 13 checked, `no_match`=1, target 0/o0, `shift`=0, latency 14.
  - Stimulus: `scale`=0 with any note.
  - Required: same exhaustion result.
- Invalid notes and dropped events, STABLE_FRAMES=2:
  - Stimulus: note 15 between two identical valid notes.
  - Required: the counter resets and no search starts.
  - Stimulus: `note_done` pulses during SEARCH.
  - Required: ignored; the result matches the undisturbed case.
- Reset mid-search:
  - Stimulus: assert `reset` 3 cycles into a 14-cycle search.
  - Required: all outputs 0 the next cycle, no pulse afterward.
  - Follow-up: with STABLE_FRAMES=2, a single new `note_done` does not trigger a search.
